// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg -- shared state encoding, error read value and slot-index width helper.
// Revision 1.0
`default_nettype none

package mmio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] RD_ERR = 32'hFFFF_FFFF;

    function automatic int slot_idx_w(input int n_slot);
        return (n_slot > 1) ? $clog2(n_slot) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_slot_dec.sv
// mmio_slot_dec -- slot index to one-hot select plus populated flag.
// Revision 1.0
`default_nettype none

module mmio_slot_dec
    import mmio_ctrl_pkg::*;
#(
    parameter int          N_SLOT   = 64,
    parameter logic [63:0] POP_MASK = 64'h0000_0000_0000_020F,
    localparam int         SW       = slot_idx_w(N_SLOT)
) (
    input  logic [SW-1:0]     i_slot,
    output logic [N_SLOT-1:0] o_onehot,
    output logic              o_populated
);

    logic [N_SLOT-1:0] w_pop_vec;

    assign w_pop_vec   = POP_MASK[N_SLOT-1:0];
    assign o_onehot    = {{(N_SLOT-1){1'b0}}, 1'b1} << i_slot;
    assign o_populated = w_pop_vec[i_slot];

endmodule

`default_nettype wire

// File: rtl/mmio_ctrl_ws.sv
// mmio_ctrl_ws -- MMIO bus to slot bridge with per-slot strobes, ack timeout and error logging.
// Revision 1.0
`default_nettype none

module mmio_ctrl_ws
    import mmio_ctrl_pkg::*;
#(
    parameter int          N_SLOT   = 64,
    parameter int          REG_AW   = 5,
    parameter int          TIMEOUT  = 15,
    parameter logic [63:0] POP_MASK = 64'h0000_0000_0000_020F
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mmio_cs,
    input  logic                     mmio_wr,
    input  logic                     mmio_rd,
    input  logic [20:0]              mmio_addr,
    input  logic [31:0]              mmio_wr_data,
    output logic [31:0]              mmio_rd_data,
    output logic                     mmio_ready,
    output logic [N_SLOT-1:0]        slot_cs_array,
    output logic [N_SLOT-1:0]        slot_mem_rd_array,
    output logic [N_SLOT-1:0]        slot_mem_wr_array,
    output logic [REG_AW-1:0]        slot_reg_addr,
    output logic [31:0]              slot_wr_data,
    input  logic [N_SLOT-1:0][31:0]  slot_rd_data_array,
    input  logic [N_SLOT-1:0]        slot_ack_array,
    output logic                     bus_err,
    output logic [5:0]               err_slot,
    output logic [15:0]              err_count,
    input  logic                     err_clr
);

    localparam int SW = slot_idx_w(N_SLOT);
    localparam int AW = REG_AW + SW;

    state_t             r_state;
    state_t             w_next;
    logic [SW-1:0]      r_slot;
    logic [N_SLOT-1:0]  r_onehot;
    logic [REG_AW-1:0]  r_reg;
    logic [31:0]        r_wdata;
    logic               r_is_wr;
    logic [7:0]         r_cnt;
    logic [31:0]        r_rd_data;
    logic               r_bus_err;
    logic [5:0]         r_err_slot;
    logic [15:0]        r_err_count;

    logic [SW-1:0]      w_slot;
    logic [N_SLOT-1:0]  w_onehot;
    logic               w_pop;
    logic               w_req;
    logic               w_accept;
    logic               w_busy;
    logic               w_ack;
    logic               w_tmo;
    logic               w_log_err;
    logic [SW-1:0]      w_err_slot;
    logic               w_unused_addr;

    assign w_slot        = mmio_addr[REG_AW +: SW];
    assign w_unused_addr = ^mmio_addr[20:AW];

    mmio_slot_dec #(
        .N_SLOT   (N_SLOT),
        .POP_MASK (POP_MASK)
    ) u_dec (
        .i_slot      (w_slot),
        .o_onehot    (w_onehot),
        .o_populated (w_pop)
    );

    assign w_req      = mmio_cs & (mmio_rd | mmio_wr);
    assign w_accept   = (r_state == ST_IDLE) && w_req;
    assign w_busy     = (r_state == ST_STROBE) || (r_state == ST_WAIT);
    assign w_ack      = slot_ack_array[r_slot];
    assign w_tmo      = (r_cnt == 8'(TIMEOUT));
    assign w_log_err  = (w_accept && !w_pop) || (w_busy && !w_ack && w_tmo);
    assign w_err_slot = w_accept ? w_slot : r_slot;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_next = w_pop ? ST_STROBE : ST_DONE;
            ST_STROBE,
            ST_WAIT:   w_next = (w_ack || w_tmo) ? ST_DONE : ST_WAIT;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Read data preloads the error value on accept so unpopulated and timed-out
    // requests return it without an extra path; an ack overwrites it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot    <= '0;
            r_onehot  <= '0;
            r_reg     <= '0;
            r_wdata   <= '0;
            r_is_wr   <= 1'b0;
            r_cnt     <= '0;
            r_rd_data <= '0;
        end else if (w_accept) begin
            r_slot    <= w_slot;
            r_onehot  <= w_onehot;
            r_reg     <= mmio_addr[REG_AW-1:0];
            r_wdata   <= mmio_wr_data;
            r_is_wr   <= mmio_wr;
            r_cnt     <= '0;
            r_rd_data <= RD_ERR;
        end else if (w_busy) begin
            if (w_ack) r_rd_data <= slot_rd_data_array[r_slot];
            else       r_cnt     <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus_err   <= 1'b0;
            r_err_slot  <= '0;
            r_err_count <= '0;
        end else if (w_log_err) begin
            r_bus_err   <= 1'b1;
            r_err_slot  <= 6'(w_err_slot);
            if (err_clr)                     r_err_count <= 16'd1;
            else if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end else if (err_clr) begin
            r_bus_err   <= 1'b0;
            r_err_count <= '0;
        end
    end

    assign mmio_ready        = (r_state == ST_DONE);
    assign mmio_rd_data      = mmio_ready ? r_rd_data : '0;
    assign slot_cs_array     = w_busy ? r_onehot : '0;
    assign slot_mem_rd_array = ((r_state == ST_STROBE) && !r_is_wr) ? r_onehot : '0;
    assign slot_mem_wr_array = ((r_state == ST_STROBE) &&  r_is_wr) ? r_onehot : '0;
    assign slot_reg_addr     = r_reg;
    assign slot_wr_data      = r_wdata;
    assign bus_err           = r_bus_err;
    assign err_slot          = r_err_slot;
    assign err_count         = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_mmio_ctrl_ws.sv
// tb_mmio_ctrl_ws -- vector table plus directed sequences for mmio_ctrl_ws.
// Revision 1.0
`default_nettype none

module tb_mmio_ctrl_ws;

    logic               clk = 1'b0;
    logic               reset;
    logic               mmio_cs, mmio_wr, mmio_rd, err_clr;
    logic [20:0]        mmio_addr;
    logic [31:0]        mmio_wr_data;
    logic [31:0]        mmio_rd_data;
    logic               mmio_ready;
    logic [63:0]        slot_cs_array, slot_mem_rd_array, slot_mem_wr_array;
    logic [4:0]         slot_reg_addr;
    logic [31:0]        slot_wr_data;
    logic [63:0][31:0]  slot_rd_data_array;
    logic [63:0]        slot_ack_array;
    logic               bus_err;
    logic [5:0]         err_slot;
    logic [15:0]        err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_ctrl_ws #(
        .N_SLOT   (64),
        .REG_AW   (5),
        .TIMEOUT  (15),
        .POP_MASK (64'h0000_0000_0000_020F)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mmio_cs            (mmio_cs),
        .mmio_wr            (mmio_wr),
        .mmio_rd            (mmio_rd),
        .mmio_addr          (mmio_addr),
        .mmio_wr_data       (mmio_wr_data),
        .mmio_rd_data       (mmio_rd_data),
        .mmio_ready         (mmio_ready),
        .slot_cs_array      (slot_cs_array),
        .slot_mem_rd_array  (slot_mem_rd_array),
        .slot_mem_wr_array  (slot_mem_wr_array),
        .slot_reg_addr      (slot_reg_addr),
        .slot_wr_data       (slot_wr_data),
        .slot_rd_data_array (slot_rd_data_array),
        .slot_ack_array     (slot_ack_array),
        .bus_err            (bus_err),
        .err_slot           (err_slot),
        .err_count          (err_count),
        .err_clr            (err_clr)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [5:0]  slot;
        logic [4:0]  rg;
        logic [31:0] wdata;
        int          ack_dly;   // cycles after the strobe cycle; -1 = never
        logic [31:0] adata;
        logic        noise;     // hold acks high on every other slot
        int          lat;
        logic        chk_rd;
        logic [31:0] rdata;
        int          n_rd;
        int          n_wr;
        logic        berr;
        logic [15:0] ecnt;
        logic [5:0]  eslot;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mmio_cs = 1'b0;
        mmio_rd = 1'b0;
        mmio_wr = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int req2_k, input int clr_k,
                           output int lat, output logic [31:0] rdata,
                           output int n_rd, output int n_wr,
                           output logic [4:0] rg_seen, output logic [31:0] wd_seen,
                           output logic cs_ok, output logic zero_ok);
        logic [63:0] oh;
        logic        a;
        oh = 64'd1 << v.slot;
        lat = -1; rdata = '0; n_rd = 0; n_wr = 0;
        rg_seen = '0; wd_seen = '0; cs_ok = 1'b1; zero_ok = 1'b1;
        slot_rd_data_array[v.slot] = v.adata;
        @(negedge clk);
        mmio_cs = 1'b1; mmio_rd = v.rd; mmio_wr = v.wr;
        mmio_addr = {10'd0, v.slot, v.rg}; mmio_wr_data = v.wdata;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            drive_idle();
            if (k == req2_k) begin
                mmio_cs = 1'b1; mmio_wr = 1'b1;
                mmio_addr = {10'd0, 6'd2, 5'd3}; mmio_wr_data = 32'h0000_0BAD;
            end
            err_clr = (k == clr_k);
            a = (v.ack_dly >= 0) && (k >= 1 + v.ack_dly);
            slot_ack_array = (v.noise ? ~oh : 64'd0) | (a ? oh : 64'd0);
            if (|slot_mem_rd_array) begin
                n_rd++;
                if (slot_mem_rd_array !== oh) cs_ok = 1'b0;
                rg_seen = slot_reg_addr; wd_seen = slot_wr_data;
            end
            if (|slot_mem_wr_array) begin
                n_wr++;
                if (slot_mem_wr_array !== oh) cs_ok = 1'b0;
                rg_seen = slot_reg_addr; wd_seen = slot_wr_data;
            end
            if (mmio_ready) begin
                lat = k;
                rdata = mmio_rd_data;
                if (slot_cs_array !== 64'd0) cs_ok = 1'b0;
            end else begin
                if (mmio_rd_data !== 32'd0) zero_ok = 1'b0;
                if (slot_cs_array !== ((v.n_rd + v.n_wr > 0) ? oh : 64'd0)) cs_ok = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            drive_idle();
            slot_ack_array = '0;
            if (|slot_mem_rd_array) n_rd++;
            if (|slot_mem_wr_array) n_wr++;
            if (mmio_ready) cs_ok = 1'b0;
        end
    endtask

    task automatic apply_vec(input string tag, input vec_t v, input int req2_k, input int clr_k);
        int          lat, n_rd, n_wr;
        logic [31:0] rdata, wd_seen;
        logic [4:0]  rg_seen;
        logic        cs_ok, zero_ok;
        run_txn(v, req2_k, clr_k, lat, rdata, n_rd, n_wr, rg_seen, wd_seen, cs_ok, zero_ok);
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        if (v.chk_rd) chk({tag, " rd_data"}, 64'(rdata), 64'(v.rdata));
        chk({tag, " rd strobes"}, 64'(n_rd), 64'(v.n_rd));
        chk({tag, " wr strobes"}, 64'(n_wr), 64'(v.n_wr));
        if (v.n_rd + v.n_wr > 0) chk({tag, " reg addr"}, 64'(rg_seen), 64'(v.rg));
        if (v.n_wr > 0) chk({tag, " wr data"}, 64'(wd_seen), 64'(v.wdata));
        chk({tag, " select ok"}, 64'(cs_ok), 64'd1);
        chk({tag, " rd_data zero idle"}, 64'(zero_ok), 64'd1);
        chk({tag, " bus_err"}, 64'(bus_err), 64'(v.berr));
        chk({tag, " err_count"}, 64'(err_count), 64'(v.ecnt));
        chk({tag, " err_slot"}, 64'(err_slot), 64'(v.eslot));
    endtask

    vec_t tbl[7];
    vec_t va;
    vec_t vb;
    int   n_late;

    initial begin
        // wr rd slot rg wdata ack adata noise | lat chk rdata n_rd n_wr berr ecnt eslot
        tbl[0] = '{1'b0, 1'b1, 6'd3,  5'd2,  32'h0,  0, 32'h0000_00A5, 1'b0,  2, 1'b1, 32'h0000_00A5, 1, 0, 1'b0, 16'd0, 6'd0};
        tbl[1] = '{1'b1, 1'b0, 6'd2,  5'd1,  32'h55, 4, 32'h0,         1'b0,  6, 1'b0, 32'h0,         0, 1, 1'b0, 16'd0, 6'd0};
        tbl[2] = '{1'b0, 1'b1, 6'd7,  5'd0,  32'h0, -1, 32'h0,         1'b0,  1, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b1, 16'd1, 6'd7};
        tbl[3] = '{1'b0, 1'b1, 6'd9,  5'd6,  32'h0,  2, 32'h1234_5678, 1'b1,  4, 1'b1, 32'h1234_5678, 1, 0, 1'b1, 16'd1, 6'd7};
        tbl[4] = '{1'b0, 1'b1, 6'd0,  5'd0,  32'h0, -1, 32'h0,         1'b0, 17, 1'b1, 32'hFFFF_FFFF, 1, 0, 1'b1, 16'd2, 6'd0};
        tbl[5] = '{1'b1, 1'b1, 6'd1,  5'd4,  32'hC3, 1, 32'h0,         1'b0,  3, 1'b0, 32'h0,         0, 1, 1'b1, 16'd2, 6'd0};
        tbl[6] = '{1'b0, 1'b1, 6'd63, 5'd31, 32'h0, -1, 32'h0,         1'b0,  1, 1'b1, 32'hFFFF_FFFF, 0, 0, 1'b1, 16'd3, 6'd63};
        va     = '{1'b0, 1'b1, 6'd1,  5'd2,  32'h0, -1, 32'h0,         1'b0, 17, 1'b1, 32'hFFFF_FFFF, 1, 0, 1'b1, 16'd1, 6'd1};
        vb     = '{1'b0, 1'b1, 6'd3,  5'd5,  32'h0,  0, 32'h0000_0077, 1'b0,  2, 1'b1, 32'h0000_0077, 1, 0, 1'b0, 16'd0, 6'd0};

        reset = 1'b0;
        drive_idle();
        mmio_addr = '0; mmio_wr_data = '0; slot_ack_array = '0;
        for (int i = 0; i < 64; i++) slot_rd_data_array[i] = 32'hDEAD_0000 | 32'(i);
        repeat (3) @(negedge clk);
        chk("reset mmio_ready", 64'(mmio_ready), 64'd0);
        chk("reset rd_data", 64'(mmio_rd_data), 64'd0);
        chk("reset slot_cs", slot_cs_array, 64'd0);
        chk("reset strobes", slot_mem_rd_array | slot_mem_wr_array, 64'd0);
        chk("reset errs", {31'd0, bus_err, 10'd0, err_slot, err_count}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            apply_vec($sformatf("vec%0d", i), tbl[i], -1, -1);

        // Timeout on slot 1 with a second request during WAIT and err_clr on the timeout edge.
        apply_vec("clr+timeout", va, 3, 16);

        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_clr bus_err", 64'(bus_err), 64'd0);
        chk("err_clr err_count", 64'(err_count), 64'd0);
        chk("err_clr keeps err_slot", 64'(err_slot), 64'd1);

        // Reset pulsed while waiting on an ack from slot 2.
        @(negedge clk);
        mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_addr = {10'd0, 6'd2, 5'd9};
        @(negedge clk); drive_idle();
        repeat (2) @(negedge clk);
        chk("pre-reset slot_cs", slot_cs_array, 64'h4);
        reset = 1'b0;
        #1;
        chk("mid reset slot_cs", slot_cs_array, 64'd0);
        chk("mid reset ready", 64'(mmio_ready), 64'd0);
        chk("mid reset rd_data", 64'(mmio_rd_data), 64'd0);
        chk("mid reset reg addr", 64'(slot_reg_addr), 64'd0);
        chk("mid reset err_slot", 64'(err_slot), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_late = 0;
        repeat (20) begin
            @(negedge clk);
            if (mmio_ready || (|slot_mem_rd_array) || (|slot_mem_wr_array) || (|slot_cs_array))
                n_late++;
        end
        chk("post-reset activity", 64'(n_late), 64'd0);
        apply_vec("post-reset", vb, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
